// File: rtl/sw_job_sequencer.sv
// Runs up to JOB_DEPTH engine jobs (set_t once, then load/start/collect per job); results readable with 1-cycle latency.
// Waits on engine i_busy/i_valid handshakes; optional watchdog via SW_SEQ_TIMEOUT_EN.
module sw_job_sequencer #(
    parameter int JOB_DEPTH   = 4,
    parameter int RESULT_W    = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_cfg_we,
    input  logic [$clog2(JOB_DEPTH)-1:0] i_cfg_addr,
    input  logic [15:0]                  i_cfg_data,
    input  logic [$clog2(JOB_DEPTH):0]   i_num_jobs,
    input  logic                         i_reload_t,
    input  logic                         i_go,
    input  logic [$clog2(JOB_DEPTH)-1:0] i_res_raddr,
    output logic [RESULT_W-1:0]          o_res_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err,
    output logic [$clog2(JOB_DEPTH):0]   o_jobs_done,
    output logic                         o_set_t,
    output logic                         o_start_cal,
    output logic [3:0]                   o_match,
    output logic [3:0]                   o_mismatch,
    output logic [3:0]                   o_minusAlpha,
    output logic [3:0]                   o_minusBeta,
    input  logic                         i_busy,
    input  logic                         i_valid,
    input  logic [RESULT_W-1:0]          i_result
);

    localparam int AW = $clog2(JOB_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_T,
        S_WAIT_T,
        S_LOAD,
        S_START,
        S_WAIT_VALID,
        S_WAIT_IDLE,
`ifdef SW_SEQ_TIMEOUT_EN
        S_ERR,
`endif
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                t_loaded_q, t_loaded_d;
    logic                tseen_q, tseen_d;
    logic [AW:0]         job_q, job_d;
    logic [AW:0]         num_q, num_d;
    logic [AW:0]         jobs_done_q, jobs_done_d;
    logic [15:0]         par_q, par_d;
    logic [RESULT_W-1:0] res_data_q;

    logic [15:0]         param_mem [JOB_DEPTH];
    logic [RESULT_W-1:0] res_mem   [JOB_DEPTH];

    logic                busy;
    logic                cfg_wr;
    logic                res_wr;
    logic [AW:0]         num_clamped;
    logic [AW:0]         job_inc;

`ifdef SW_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic           err_q, err_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           waiting;
`endif

    assign num_clamped = (i_num_jobs > (AW+1)'(JOB_DEPTH)) ? (AW+1)'(JOB_DEPTH) : i_num_jobs;
    assign job_inc     = job_q + (AW+1)'(1);

    always_comb begin
        busy = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef SW_SEQ_TIMEOUT_EN
        busy = busy && (state_q != S_ERR);
`endif
    end

    assign cfg_wr = i_cfg_we && !busy;

    always_comb begin
        state_d     = state_q;
        t_loaded_d  = t_loaded_q;
        tseen_d     = tseen_q;
        job_d       = job_q;
        num_d       = num_q;
        jobs_done_d = jobs_done_q;
        par_d       = par_q;
        res_wr      = 1'b0;
`ifdef SW_SEQ_TIMEOUT_EN
        err_d       = err_q;
        wdog_d      = wdog_q;
        waiting     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    job_d       = '0;
                    jobs_done_d = '0;
                    num_d       = num_clamped;
                    tseen_d     = 1'b0;
`ifdef SW_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    if (num_clamped == '0) begin
                        state_d = S_DONE;
                    end else if (i_reload_t || !t_loaded_q) begin
                        state_d = S_SET_T;
                    end else begin
                        state_d = S_LOAD;
                        par_d   = param_mem[0];
                    end
                end
            end
            S_SET_T: begin
                tseen_d = 1'b0;
                state_d = S_WAIT_T;
            end
            S_WAIT_T: begin
`ifdef SW_SEQ_TIMEOUT_EN
                waiting = 1'b1;
`endif
                if (i_busy) begin
                    tseen_d = 1'b1;
                end else if (tseen_q) begin
                    t_loaded_d = 1'b1;
                    state_d    = S_LOAD;
                    par_d      = param_mem[job_q[AW-1:0]];
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_WAIT_VALID;
            S_WAIT_VALID: begin
`ifdef SW_SEQ_TIMEOUT_EN
                waiting = 1'b1;
`endif
                if (i_valid) begin
                    res_wr  = 1'b1;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
`ifdef SW_SEQ_TIMEOUT_EN
                waiting = 1'b1;
`endif
                if (!i_busy) begin
                    job_d       = job_inc;
                    jobs_done_d = jobs_done_q + (AW+1)'(1);
                    if (job_inc < num_q) begin
                        state_d = S_LOAD;
                        par_d   = param_mem[job_inc[AW-1:0]];
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
`ifdef SW_SEQ_TIMEOUT_EN
            S_ERR:   state_d = S_IDLE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef SW_SEQ_TIMEOUT_EN
        // Watchdog overrides any handshake seen in the expiring cycle.
        if (waiting && (wdog_q == WDW'(TIMEOUT_CYC - 1))) begin
            state_d     = S_ERR;
            err_d       = 1'b1;
            t_loaded_d  = 1'b0;
            res_wr      = 1'b0;
            job_d       = job_q;
            jobs_done_d = jobs_done_q;
            par_d       = par_q;
        end
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (waiting) begin
            wdog_d = wdog_q + WDW'(1);
        end else begin
            wdog_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            t_loaded_q  <= 1'b0;
            tseen_q     <= 1'b0;
            job_q       <= '0;
            num_q       <= '0;
            jobs_done_q <= '0;
            par_q       <= '0;
            res_data_q  <= '0;
`ifdef SW_SEQ_TIMEOUT_EN
            err_q       <= 1'b0;
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            t_loaded_q  <= t_loaded_d;
            tseen_q     <= tseen_d;
            job_q       <= job_d;
            num_q       <= num_d;
            jobs_done_q <= jobs_done_d;
            par_q       <= par_d;
            res_data_q  <= res_mem[i_res_raddr];
`ifdef SW_SEQ_TIMEOUT_EN
            err_q       <= err_d;
            wdog_q      <= wdog_d;
`endif
        end
    end

    // Slot storage survives reset so results can be read after an abort.
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            param_mem[i_cfg_addr] <= i_cfg_data;
        end
        if (res_wr) begin
            res_mem[job_q[AW-1:0]] <= i_result;
        end
    end

    assign o_busy       = busy;
    assign o_done       = (state_q == S_DONE)
`ifdef SW_SEQ_TIMEOUT_EN
                          || (state_q == S_ERR)
`endif
                          ;
`ifdef SW_SEQ_TIMEOUT_EN
    assign o_err        = err_q;
`else
    assign o_err        = 1'b0;
`endif
    assign o_set_t      = (state_q == S_SET_T);
    assign o_start_cal  = (state_q == S_START);
    assign o_jobs_done  = jobs_done_q;
    assign o_res_data   = res_data_q;
    assign o_match      = par_q[15:12];
    assign o_mismatch   = par_q[11:8];
    assign o_minusAlpha = par_q[7:4];
    assign o_minusBeta  = par_q[3:0];

endmodule

// File: tb/tb_sw_job_sequencer.sv
// Directed bench for sw_job_sequencer with a behavioural engine model (10-cycle busy, valid on last busy cycle).
module tb_sw_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_addr;
    logic [15:0] i_cfg_data;
    logic [2:0]  i_num_jobs;
    logic        i_reload_t;
    logic        i_go;
    logic [1:0]  i_res_raddr;
    logic [15:0] o_res_data;
    logic        o_busy, o_done, o_err;
    logic [2:0]  o_jobs_done;
    logic        o_set_t, o_start_cal;
    logic [3:0]  o_match, o_mismatch, o_minusAlpha, o_minusBeta;
    logic        i_busy, i_valid;
    logic [15:0] i_result;

    int checks   = 0;
    int failures = 0;

    int set_cnt, start_cnt, done_cnt, res_idx, eng_cnt;
    bit is_cal, suppress;
    logic [15:0] res_tbl [8];
    logic [15:0] cap     [8];

    sw_job_sequencer #(.JOB_DEPTH(4), .RESULT_W(16), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .i_num_jobs(i_num_jobs), .i_reload_t(i_reload_t), .i_go(i_go),
        .i_res_raddr(i_res_raddr), .o_res_data(o_res_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_jobs_done(o_jobs_done),
        .o_set_t(o_set_t), .o_start_cal(o_start_cal),
        .o_match(o_match), .o_mismatch(o_mismatch),
        .o_minusAlpha(o_minusAlpha), .o_minusBeta(o_minusBeta),
        .i_busy(i_busy), .i_valid(i_valid), .i_result(i_result)
    );

    always #5 clk = ~clk;

    // Engine model and pulse monitor, evaluated 1 time unit after each edge.
    initial begin
        eng_cnt = 0; is_cal = 1'b0; i_busy = 1'b0; i_valid = 1'b0; i_result = '0;
        set_cnt = 0; start_cnt = 0; done_cnt = 0; res_idx = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                eng_cnt = 0; i_busy = 1'b0; i_valid = 1'b0;
            end else begin
                if (o_set_t) set_cnt++;
                if (o_done) done_cnt++;
                if (o_start_cal) begin
                    cap[start_cnt % 8] = {o_match, o_mismatch, o_minusAlpha, o_minusBeta};
                    start_cnt++;
                end
                if (o_set_t || o_start_cal) begin
                    eng_cnt = 10;
                    is_cal  = o_start_cal;
                end
                i_valid  = is_cal && (eng_cnt == 1) && !suppress;
                i_result = res_tbl[res_idx % 8];
                if (i_valid) res_idx++;
                i_busy = (eng_cnt > 0);
                if (eng_cnt > 0) eng_cnt--;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        i_cfg_we = 1'b1; i_cfg_addr = addr; i_cfg_data = data;
        step();
        i_cfg_we = 1'b0;
    endtask

    task automatic go(input logic [2:0] num, input logic reload);
        set_cnt = 0; start_cnt = 0; done_cnt = 0; res_idx = 0;
        i_num_jobs = num; i_reload_t = reload; i_go = 1'b1;
        step();
        i_go = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cycles, output bit ok);
        cycles = 0;
        while (!o_done && cycles < max) begin
            step();
            cycles++;
        end
        ok = o_done;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [15:0] val);
        i_res_raddr = addr;
        step();
        val = o_res_data;
    endtask

    initial begin
        int cyc;
        bit ok;
        int busy_drop;
        logic [15:0] v;

        rst = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
        i_num_jobs = '0; i_reload_t = 1'b0; i_go = 1'b0; i_res_raddr = '0; suppress = 1'b0;
        for (int i = 0; i < 8; i++) begin
            res_tbl[i] = '0;
            cap[i] = '0;
        end
        repeat (3) step();
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_pulses", {o_set_t, o_start_cal}, 0);
        chk("rst_params", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, 0);
        chk("rst_jobs_done", o_jobs_done, 0);
        chk("rst_res_data", o_res_data, 0);
        rst = 1'b0;
        step();

        cfg_write(2'd0, 16'h21A1);
        cfg_write(2'd1, 16'h3221);
        cfg_write(2'd2, 16'h4321);
        cfg_write(2'd3, 16'h5678);

        // Run 1: first run always issues set_t
        res_tbl[0] = 16'd27; res_tbl[1] = 16'd41;
        go(3'd2, 1'b0);
        chk("r1_busy_after_go", o_busy, 1);
        wait_done(500, cyc, ok);
        chk("r1_done_seen", ok, 1);
        chk("r1_jobs_done", o_jobs_done, 2);
        repeat (3) step();
        chk("r1_set_t_cnt", set_cnt, 1);
        chk("r1_start_cnt", start_cnt, 2);
        chk("r1_done_cnt", done_cnt, 1);
        chk("r1_busy_idle", o_busy, 0);
        chk("r1_jobs_done_hold", o_jobs_done, 2);
        chk("r1_par_job0", cap[0], 16'h21A1);
        chk("r1_par_job1", cap[1], 16'h3221);
        rd(2'd0, v); chk("r1_slot0", v, 27);
        rd(2'd1, v); chk("r1_slot1", v, 41);

        // Run 2: t already loaded, no set_t
        res_tbl[0] = 16'h0100; res_tbl[1] = 16'h0200;
        go(3'd2, 1'b0);
        chk("r2_params_load", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, 16'h21A1);
        wait_done(500, cyc, ok);
        chk("r2_done_seen", ok, 1);
        step();
        chk("r2_set_t_cnt", set_cnt, 0);
        chk("r2_start_cnt", start_cnt, 2);
        chk("r2_par_job1", cap[1], 16'h3221);
        rd(2'd1, v); chk("r2_slot1", v, 16'h0200);

        // Zero jobs
        go(3'd0, 1'b0);
        wait_done(2, cyc, ok);
        chk("zero_done_fast", ok && (cyc <= 1), 1);
        step();
        chk("zero_no_pulses", set_cnt + start_cnt, 0);
        chk("zero_jobs_done", o_jobs_done, 0);

        // Seven jobs clamp to four; go and cfg writes while busy are dropped
        res_tbl[0] = 16'h00A0; res_tbl[1] = 16'h00A1; res_tbl[2] = 16'h00A2; res_tbl[3] = 16'h00A3;
        go(3'd7, 1'b1);
        step();
        cfg_write(2'd0, 16'hFFFF);
        i_num_jobs = 3'd1; i_go = 1'b1;
        step();
        i_go = 1'b0;
        wait_done(1000, cyc, ok);
        chk("clamp_done_seen", ok, 1);
        repeat (40) step();
        chk("clamp_set_t_cnt", set_cnt, 1);
        chk("clamp_start_cnt", start_cnt, 4);
        chk("clamp_done_cnt", done_cnt, 1);
        chk("clamp_jobs_done", o_jobs_done, 4);
        chk("clamp_par_job3", cap[3], 16'h5678);
        rd(2'd3, v); chk("clamp_slot3", v, 16'h00A3);

        // Reset while job 1 waits for valid
        res_tbl[0] = 16'h0555; res_tbl[1] = 16'h0666;
        go(3'd2, 1'b0);
        chk("mid_par_job0", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, 16'h21A1);
        cyc = 0;
        while (start_cnt < 2 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("mid_reach_job1", start_cnt, 2);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done_err", {o_done, o_err}, 0);
        chk("mid_rst_pulses", {o_set_t, o_start_cal}, 0);
        chk("mid_rst_params", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, 0);
        chk("mid_rst_jobs_done", o_jobs_done, 0);
        chk("mid_rst_res_data", o_res_data, 0);
        rst = 1'b0;
        step();
        rd(2'd0, v); chk("mid_slot0_kept", v, 16'h0555);
        go(3'd1, 1'b0);
        wait_done(500, cyc, ok);
        chk("mid_restart_done", ok, 1);
        step();
        chk("mid_restart_set_t", set_cnt, 1);

        // Engine never returns valid
        suppress = 1'b1;
        go(3'd1, 1'b0);
        cyc = 0;
        while (!o_start_cal && cyc < 100) begin
            step();
            cyc++;
        end
        chk("to_start_seen", o_start_cal, 1);
`ifdef SW_SEQ_TIMEOUT_EN
        wait_done(300, cyc, ok);
        chk("to_done_seen", ok, 1);
        chk("to_done_latency", cyc, 101);
        chk("to_err", o_err, 1);
        chk("to_busy", o_busy, 0);
        step();
        chk("to_err_sticky", o_err, 1);
`else
        busy_drop = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (!o_busy) busy_drop++;
        end
        chk("to_busy_held", busy_drop, 0);
        chk("to_err_zero", o_err, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        suppress = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
